// File: rtl/uart_rx_param_if.sv
// Receiver-side signal bundle: the serial line in, the received word and its
// status strobes out. DATA_W must match the receiver it is attached to.
interface uart_rx_param_if #(
  parameter int DATA_W = 8
);
  logic              rxd;
  logic [DATA_W-1:0] word;
  logic              word_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // The receiver owns the word stream and listens to the line.
  modport master (
    input  rxd,
    output word,
    output word_valid,
    output parity_err,
    output frame_err,
    output busy
  );

  // The line driver / word consumer side.
  modport slave (
    output rxd,
    input  word,
    input  word_valid,
    input  parity_err,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: two-flop synchroniser, mid-bit sampling with
// CLKS_PER_BIT oversampling, configurable width, bit order, parity and stop
// bits. Each frame ends with a one-cycle word_valid or frame_err strobe.
module uart_rx_param #(
  parameter int DATA_W       = 8,  // 5..9
  parameter int CLKS_PER_BIT = 16, // even, >= 4
  parameter int PARITY       = 0,  // 0 none, 1 even, 2 odd
  parameter bit MSB_FIRST    = 1'b1,
  parameter int STOP_BITS    = 1   // 1 or 2
) (
  input logic clk,
  input logic rst,
  uart_rx_param_if.master bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);

  // Counter end values: half a bit to reach the middle of the start bit,
  // then a full bit between successive mid-bit samples.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic             ODD_PAR   = (PARITY == 2);
  localparam int               SYNC_W    = 2;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY_BIT,
    STOP
  } state_t;

  state_t            state_reg;
  logic [SYNC_W-1:0] sync_reg;
  logic              rxd_s;
  logic [CNT_W-1:0]  cnt_reg;
  logic [IDX_W-1:0]  idx_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              par_bad_reg;
  logic              stop_bad_reg;
  logic              par_expect;
  logic [DATA_W-1:0] word_reg;
  logic              word_valid_reg;
  logic              parity_err_reg;
  logic              frame_err_reg;
  logic              busy_reg;

  // Two-stage synchroniser on the asynchronous line; resets to 0 so a line
  // that is really high is only trusted once it has propagated through.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_W-2:0], bus.rxd};
    end
  end

  assign rxd_s = sync_reg[SYNC_W-1];

  // Next shift-register value for a data sample, placed per bit order.
  always_comb begin
    shift_next = shift_reg;
    if (MSB_FIRST) begin
      shift_next = {shift_reg[DATA_W-2:0], rxd_s};
    end else begin
      shift_next = {rxd_s, shift_reg[DATA_W-1:1]};
    end
  end

  // Value the parity bit should carry for the data now in the shift register.
  assign par_expect = (^shift_reg) ^ ODD_PAR;

  // Frame FSM with all outputs registered; strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= WAIT_HIGH;
      cnt_reg        <= '0;
      idx_reg        <= '0;
      shift_reg      <= '0;
      par_bad_reg    <= 1'b0;
      stop_bad_reg   <= 1'b0;
      word_reg       <= '0;
      word_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      word_valid_reg <= 1'b0;
      parity_err_reg <= 1'b0;
      frame_err_reg  <= 1'b0;
      case (state_reg)
        // A line stuck low (break, unplugged cable) must go high before
        // any falling edge counts as a start bit.
        WAIT_HIGH: begin
          if (rxd_s) begin
            state_reg <= IDLE;
          end
        end
        IDLE: begin
          if (!rxd_s) begin
            state_reg    <= START;
            cnt_reg      <= '0;
            busy_reg     <= 1'b1;
            par_bad_reg  <= 1'b0;
            stop_bad_reg <= 1'b0;
          end
        end
        // Re-check the start bit at its midpoint to reject glitches.
        START: begin
          if (cnt_reg == HALF_LAST) begin
            cnt_reg <= '0;
            if (!rxd_s) begin
              state_reg <= DATA;
              idx_reg   <= '0;
            end else begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        DATA: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg   <= '0;
            shift_reg <= shift_next;
            if (idx_reg == DATA_LAST) begin
              idx_reg   <= '0;
              state_reg <= (PARITY != 0) ? PARITY_BIT : STOP;
            end else begin
              idx_reg <= idx_reg + IDX_ONE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        PARITY_BIT: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg     <= '0;
            idx_reg     <= '0;
            par_bad_reg <= rxd_s ^ par_expect;
            state_reg   <= STOP;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        // Every stop sample must be 1; a bad frame leaves word untouched
        // and waits for the line to recover before hunting for a start.
        STOP: begin
          if (cnt_reg == BIT_LAST) begin
            cnt_reg <= '0;
            if (idx_reg == STOP_LAST) begin
              idx_reg      <= '0;
              busy_reg     <= 1'b0;
              stop_bad_reg <= 1'b0;
              if (stop_bad_reg || !rxd_s) begin
                frame_err_reg <= 1'b1;
                state_reg     <= WAIT_HIGH;
              end else begin
                word_reg       <= shift_reg;
                word_valid_reg <= 1'b1;
                parity_err_reg <= par_bad_reg;
                state_reg      <= IDLE;
              end
            end else begin
              idx_reg      <= idx_reg + IDX_ONE;
              stop_bad_reg <= stop_bad_reg | ~rxd_s;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end
        default: begin
          state_reg <= WAIT_HIGH;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word       = word_reg;
  assign bus.word_valid = word_valid_reg;
  assign bus.parity_err = parity_err_reg;
  assign bus.frame_err  = frame_err_reg;
  assign bus.busy       = busy_reg;

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (default, even parity, 7-bit
// LSB-first with two stop bits) driven by directed frames. Expected results
// are queued when a frame is sent; a monitor pops and compares on strobes.
module tb_uart_rx_param;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_a = 1'b1;
  logic rxd_b = 1'b1;
  logic rxd_c = 1'b1;
  logic [31:0] cyc = 0;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [8:0]  word;
    logic        wv;
    logic        pe;
    logic        fe;
    logic [31:0] cyc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t qc[$];

  uart_rx_param_if #(.DATA_W(8)) ia ();
  uart_rx_param_if #(.DATA_W(8)) ib ();
  uart_rx_param_if #(.DATA_W(7)) ic ();

  assign ia.rxd = rxd_a;
  assign ib.rxd = rxd_b;
  assign ic.rxd = rxd_c;

  uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(N), .PARITY(0), .MSB_FIRST(1'b1), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia.master));
  uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(N), .PARITY(1), .MSB_FIRST(1'b1), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib.master));
  uart_rx_param #(.DATA_W(7), .CLKS_PER_BIT(N), .PARITY(0), .MSB_FIRST(1'b0), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst), .bus(ic.master));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cyc %0d)", name, got, exp_v, cyc);
    end else begin
      $display("ok   %s = %0h (cyc %0d)", name, got, cyc);
    end
  endtask

  task automatic set_rxd(input int d, input logic v);
    case (d)
      0: rxd_a = v;
      1: rxd_b = v;
      default: rxd_c = v;
    endcase
  endtask

  // Called at a negedge; T0 (receiver sees the start) is 3 posedges later,
  // the strobe follows after half a bit plus all post-start bits.
  task automatic send_frame(input int d, input logic [8:0] data, input int dw, input bit msb,
                            input int pbit, input int sb, input logic stop_val,
                            input logic [8:0] exp_word, input logic exp_pe, input logic exp_fe);
    exp_t e;
    int p;
    p = (pbit >= 0) ? 1 : 0;
    e.word = exp_word;
    e.wv   = ~exp_fe;
    e.pe   = exp_pe;
    e.fe   = exp_fe;
    e.cyc  = cyc + 32'(3 + N / 2 + (dw + p + sb) * N);
    case (d)
      0: qa.push_back(e);
      1: qb.push_back(e);
      default: qc.push_back(e);
    endcase
    set_rxd(d, 1'b0);
    repeat (N) @(negedge clk);
    for (int i = 0; i < dw; i++) begin
      set_rxd(d, msb ? data[dw-1-i] : data[i]);
      repeat (N) @(negedge clk);
    end
    if (pbit >= 0) begin
      set_rxd(d, pbit[0]);
      repeat (N) @(negedge clk);
    end
    for (int i = 0; i < sb; i++) begin
      set_rxd(d, stop_val);
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic score(input int d, input logic [8:0] w, input logic wv, input logic pe, input logic fe);
    exp_t e;
    bit have;
    have = 1'b0;
    e = '0;
    case (d)
      0: if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
      1: if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
      default: if (qc.size() > 0) begin e = qc.pop_front(); have = 1'b1; end
    endcase
    checks++;
    if (!have) begin
      errors++;
      $display("FAIL strobe_dut%0d unexpected: word %0h wv %b pe %b fe %b at cyc %0d, required none",
               d, w, wv, pe, fe, cyc);
    end else if (w !== e.word || wv !== e.wv || pe !== e.pe || fe !== e.fe || cyc !== e.cyc) begin
      errors++;
      $display("FAIL strobe_dut%0d got word %0h wv %b pe %b fe %b cyc %0d, required word %0h wv %b pe %b fe %b cyc %0d",
               d, w, wv, pe, fe, cyc, e.word, e.wv, e.pe, e.fe, e.cyc);
    end else begin
      $display("ok   strobe_dut%0d word %0h wv %b pe %b fe %b cyc %0d", d, w, wv, pe, fe, cyc);
    end
  endtask

  // Monitor: any strobe from any receiver is matched against its queue.
  always @(negedge clk) begin
    if (ia.word_valid || ia.parity_err || ia.frame_err)
      score(0, 9'(ia.word), ia.word_valid, ia.parity_err, ia.frame_err);
    if (ib.word_valid || ib.parity_err || ib.frame_err)
      score(1, 9'(ib.word), ib.word_valid, ib.parity_err, ib.frame_err);
    if (ic.word_valid || ic.parity_err || ic.frame_err)
      score(2, 9'(ic.word), ic.word_valid, ic.parity_err, ic.frame_err);
  end

  initial begin
    logic [31:0] c;
    logic [7:0]  part;

    // Reset state
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_word_a", 32'(ia.word), 0);
    chk("reset_busy_a", 32'(ia.busy), 0);
    chk("reset_flags_a", {29'd0, ia.word_valid, ia.parity_err, ia.frame_err}, 0);
    chk("reset_word_c", 32'(ic.word), 0);
    repeat (10) @(negedge clk);

    // False start: 4 clocks low, busy high for exactly 8 cycles
    c = cyc;
    rxd_a = 1'b0;
    repeat (2) @(negedge clk);
    chk("false_busy_before", 32'(ia.busy), 0);
    @(negedge clk);
    chk("false_busy_first", 32'(ia.busy), 1);
    @(negedge clk);
    rxd_a = 1'b1;
    repeat (6) @(negedge clk);
    chk("false_busy_last", 32'(ia.busy), 1);
    @(negedge clk);
    chk("false_busy_drop", 32'(ia.busy), 0);
    chk("false_word_held", 32'(ia.word), 0);
    repeat (20) @(negedge clk);
    send_frame(0, 9'h03C, 8, 1'b1, -1, 1, 1'b1, 9'h03C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // 0xA5 with busy timing around T0 and completion
    c = cyc;
    fork
      send_frame(0, 9'h0A5, 8, 1'b1, -1, 1, 1'b1, 9'h0A5, 1'b0, 1'b0);
      begin
        repeat (2) @(negedge clk);
        chk("a5_busy_pre", 32'(ia.busy), 0);
        @(negedge clk);
        chk("a5_busy_rise", 32'(ia.busy), 1);
        repeat (151) @(negedge clk);
        chk("a5_busy_end", 32'(ia.busy), 1);
        @(negedge clk);
        chk("a5_busy_fall", 32'(ia.busy), 0);
        chk("a5_strobe_cyc", cyc - c, 155);
      end
    join
    repeat (10) @(negedge clk);

    // Even parity: 0x03 with wrong parity bit, then correct one
    send_frame(1, 9'h003, 8, 1'b1, 1, 1, 1'b1, 9'h003, 1'b1, 1'b0);
    send_frame(1, 9'h003, 8, 1'b1, 0, 1, 1'b1, 9'h003, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Framing error, line held low, then recovery
    send_frame(0, 9'h011, 8, 1'b1, -1, 1, 1'b1, 9'h011, 1'b0, 1'b0);
    send_frame(0, 9'h077, 8, 1'b1, -1, 1, 1'b0, 9'h011, 1'b0, 1'b1);
    repeat (100) @(negedge clk);
    chk("break_word_held", 32'(ia.word), 32'h11);
    chk("break_busy", 32'(ia.busy), 0);
    rxd_a = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(0, 9'h03C, 8, 1'b1, -1, 1, 1'b1, 9'h03C, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // Reset with line low, then reset again mid-frame at data bit 4
    rxd_a = 1'b0;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("lowrst_word", 32'(ia.word), 0);
    chk("lowrst_busy", 32'(ia.busy), 0);
    rxd_a = 1'b1;
    repeat (10) @(negedge clk);
    part = 8'hB3;
    rxd_a = 1'b0;
    repeat (N) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd_a = part[7-i];
      repeat (N) @(negedge clk);
    end
    rxd_a = part[3];
    repeat (N / 2) @(negedge clk);
    chk("midrst_busy_before", 32'(ia.busy), 1);
    rst = 1'b1;
    rxd_a = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_outputs",
        {ia.word, 20'd0, ia.word_valid, ia.parity_err, ia.frame_err, ia.busy}, 0);
    repeat (200) @(negedge clk);
    send_frame(0, 9'h05A, 8, 1'b1, -1, 1, 1'b1, 9'h05A, 1'b0, 1'b0);
    repeat (10) @(negedge clk);

    // 7-bit LSB-first, two stop bits, back to back
    send_frame(2, 9'h055, 7, 1'b0, -1, 2, 1'b1, 9'h055, 1'b0, 1'b0);
    send_frame(2, 9'h02A, 7, 1'b0, -1, 2, 1'b1, 9'h02A, 1'b0, 1'b0);
    repeat (30) @(negedge clk);

    chk("pending_a", qa.size(), 0);
    chk("pending_b", qb.size(), 0);
    chk("pending_c", qc.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised asynchronous serial receiver, the successor to the fixed 8-bit one-sample-per-clock receiver. It synchronises the incoming serial line and oversamples each bit CLKS_PER_BIT times, sampling at mid-bit. It supports configurable data width, bit order, optional parity and 1 or 2 stop bits. It sits between the board RX pin and the byte-consuming logic, and reports each word with a one-cycle valid strobe and error flags.

Parameters:
DATA_W, 8, data bits per frame (5..9)
CLKS_PER_BIT, 16, clk cycles per serial bit; even, >= 4
PARITY, 0, 0 = none, 1 = even, 2 = odd
MSB_FIRST, 1, 1 = first data bit lands in word[DATA_W-1]; 0 = first bit lands in word[0]
STOP_BITS, 1, number of stop bits checked (1 or 2)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
rxd  input  1  asynchronous serial line; idle high
word  output  DATA_W  last accepted data word; holds until the next accepted frame
word_valid  output  1  one-cycle pulse when word is updated
parity_err  output  1  one-cycle pulse coincident with word_valid when the parity check fails; 0 when PARITY = 0
frame_err  output  1  one-cycle pulse when any stop bit samples 0
busy  output  1  high while a frame is being received (states START..STOP)

Behaviour:
- Synchroniser:
  - rxd passes through two flops to produce rxd_s.
  - Both flops reset to 0.
  - All decisions use rxd_s only.
- Reset values: word = 0, word_valid = 0, parity_err = 0, frame_err = 0, busy = 0, state = WAIT_HIGH, counters = 0.
- Reset asserted mid-frame abandons the frame; no strobes are generated for it.
- Registers:
  - Bit-time counter: $clog2(CLKS_PER_BIT) bits.
  - Bit index: $clog2(DATA_W + 1) bits.
  - Shift register: DATA_W bits.
- State WAIT_HIGH: stay until rxd_s == 1, then go to IDLE. This rejects a line held low out of reset or a break condition.
- State IDLE: rxd_s == 0 at edge T0 -> START, counter cleared.
- State START:
  - At edge T0 + CLKS_PER_BIT/2, sample rxd_s.
  - 0 -> DATA, counter and bit index cleared.
  - 1 -> false start; return to IDLE with no strobe.
- State DATA:
  - Sample every CLKS_PER_BIT cycles after the mid-start sample.
  - Shift the sample in per MSB_FIRST.
  - After DATA_W samples -> PARITY if PARITY != 0, else STOP.
- State PARITY:
  - One sample is taken.
  - Expected value = XOR of data bits (PARITY = 1), or its inverse (PARITY = 2).
  - A mismatch is latched internally.
- State STOP:
  - STOP_BITS samples are taken, each CLKS_PER_BIT apart.
  - T_last = edge of the final stop sample = T0 + CLKS_PER_BIT/2 + (DATA_W + P + STOP_BITS) * CLKS_PER_BIT, where P = 1 if parity is enabled, else 0.
- Completion, registered at edge T_last (flags high for exactly the following cycle):
  - All stop samples 1: word <= shift register, word_valid = 1, parity_err = latched mismatch; next state IDLE.
  - Any stop sample 0: frame_err = 1, word unchanged, word_valid = 0, parity_err = 0; next state WAIT_HIGH.
- busy:
  - Rises on the IDLE -> START transition.
  - Falls on the return to IDLE or WAIT_HIGH; it is low in the cycle the completion strobes are high.
- Back-to-back frames: IDLE accepts a new start on the cycle immediately after completion. No idle bit is required beyond the stop bit(s).
- rxd changes during a bit, away from the mid-point, have no effect.

Test Plan:
1. Defaults; send frame for 0xA5 (start, 1,0,1,0,0,1,0,1, stop) at 16 clk/bit -> word = 0xA5; word_valid high exactly 1 cycle at T0 + 152; parity_err = 0; frame_err = 0; busy high from T0 + 1 until T0 + 152.
2. Defaults; rxd low for 4 clk, then high -> no word_valid; busy pulses for 8 cycles; word stays 0; a following 0x3C frame is received correctly.
3. PARITY = 1; send 0x03 with parity bit 1 (expected 0) -> word = 0x03; word_valid and parity_err both pulse in the same cycle. Resend 0x03 with parity bit 0 -> word_valid pulses, parity_err = 0.
4. Defaults; receive 0x11, then a frame with stop bit 0, then rxd held low for 100 clk -> frame_err 1-cycle pulse; word stays 0x11; no further strobes while low. After rxd goes high, a frame carrying 0x3C -> word = 0x3C.
5. rxd held low across reset release, then reset asserted again mid-frame at data bit 4 -> no strobes; all outputs 0 after reset. After rxd goes high, a 0x5A frame is received correctly.
6. DATA_W = 7, MSB_FIRST = 0, STOP_BITS = 2; back-to-back frames 0x55, 0x2A with no idle gap -> two word_valid pulses 160 cycles apart; word = 0x55, then 0x2A; no errors.
